// File: rtl/pagerank_scatter_if.sv
// Handshake and result bundle for the pagerank scatter divider.
// The requester drives the operands; the scatter block returns lane results.
interface pagerank_scatter_if #(
  parameter int N_LANES = 10,
  parameter int WIDTH   = 32
);
  logic                       start;
  logic [WIDTH-1:0]           pagerank;
  logic [N_LANES-1:0]         link_mask;
  logic                       busy;
  logic [N_LANES*WIDTH-1:0]   partial_pagerank;
  logic [N_LANES-1:0]         enable;
  logic [WIDTH-1:0]           remainder;
  logic                       dangling;
  logic                       done_parallel_division;

  modport master (
    output start, pagerank, link_mask,
    input  busy, partial_pagerank, enable,
    input  remainder, dangling, done_parallel_division
  );

  modport slave (
    input  start, pagerank, link_mask,
    output busy, partial_pagerank, enable,
    output remainder, dangling, done_parallel_division
  );
endinterface

// File: rtl/pagerank_scatter.sv
// Splits a node's pagerank evenly over its outbound links.
// Bit-serial restoring divider; result fanned out to every linked lane.
module pagerank_scatter #(
  parameter int N_LANES = 10,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             reset,
  pagerank_scatter_if.slave bus
);
  localparam int DEG_W = $clog2(N_LANES + 1);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE, COUNT, DIVIDE, DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]         pr_q;
  logic [N_LANES-1:0]       mask_q;
  logic [DEG_W-1:0]         deg_q, deg_c;
  logic [DEG_W-1:0]         rem_q, rem_d;
  logic [WIDTH-1:0]         quo_q, quo_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [DEG_W:0]           trial_c;
  logic                     last_c;

  logic [N_LANES*WIDTH-1:0] part_q;
  logic [N_LANES-1:0]       en_q;
  logic [WIDTH-1:0]         remo_q;
  logic                     dang_q;

  // Out-degree is the popcount of the captured link mask.
  always_comb begin
    deg_c = '0;
    for (int i = 0; i < N_LANES; i++)
      deg_c = deg_c + DEG_W'(mask_q[i]);
  end

  // One restoring-division step: shift in the next dividend bit, try subtract.
  always_comb begin
    trial_c = {rem_q, quo_q[WIDTH-1]};
    last_c  = (cnt_q == CNT_W'(WIDTH - 1));
    if (trial_c >= {1'b0, deg_q}) begin
      rem_d = DEG_W'(trial_c - {1'b0, deg_q});
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = trial_c[DEG_W-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = COUNT;
      COUNT:   state_d = (deg_c == '0) ? DONE : DIVIDE;
      DIVIDE:  if (last_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, divider iteration and result registration.
  always_ff @(posedge clk) begin
    if (reset) begin
      pr_q   <= '0;
      mask_q <= '0;
      deg_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      part_q <= '0;
      en_q   <= '0;
      remo_q <= '0;
      dang_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            pr_q   <= bus.pagerank;
            mask_q <= bus.link_mask;
          end
        end
        COUNT: begin
          deg_q <= deg_c;
          rem_q <= '0;
          quo_q <= pr_q;
          cnt_q <= '0;
          if (deg_c == '0) begin
            part_q <= '0;
            en_q   <= '0;
            remo_q <= '0;
            dang_q <= 1'b1;
          end
        end
        DIVIDE: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_c) begin
            for (int i = 0; i < N_LANES; i++)
              part_q[i*WIDTH +: WIDTH] <= mask_q[i] ? quo_d : '0;
            en_q   <= mask_q;
            remo_q <= WIDTH'(rem_d);
            dang_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy                   = (state_q != IDLE);
  assign bus.done_parallel_division = (state_q == DONE);
  assign bus.partial_pagerank       = part_q;
  assign bus.enable                 = en_q;
  assign bus.remainder              = remo_q;
  assign bus.dangling               = dang_q;
endmodule

// File: tb/tb_pagerank_scatter.sv
// Directed bench for pagerank_scatter.
// Table of hand-computed divisions plus streaming and abort sequences.
module tb_pagerank_scatter;
  localparam int NL = 10;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  pagerank_scatter_if #(.N_LANES(NL), .WIDTH(W)) bus ();

  pagerank_scatter #(.N_LANES(NL), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  pr;
    logic [NL-1:0] mask;
    logic [W-1:0]  q;
    logic [W-1:0]  rem;
    logic          dang;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_results(input string tag, input vec_t v);
    logic [W-1:0] lane_exp;
    for (int i = 0; i < NL; i++) begin
      lane_exp = v.mask[i] ? v.q : '0;
      chk($sformatf("%s lane%0d", tag, i),
          bus.partial_pagerank[i*W +: W], lane_exp);
    end
    chk({tag, " enable"}, bus.enable, v.mask);
    chk({tag, " remainder"}, bus.remainder, v.rem);
    chk({tag, " dangling"}, bus.dangling, v.dang);
  endtask

  task automatic run_req(input vec_t v, input bit scramble);
    int cyc;
    bit seen;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.pagerank  = v.pr;
    bus.link_mask = v.mask;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (scramble) begin
      bus.pagerank  = ~v.pr;
      bus.link_mask = ~v.mask;
    end
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("busy_after_start", bus.busy, 1);
      if (bus.done_parallel_division) seen = 1'b1;
    end
    chk("latency", cyc, (v.mask == '0) ? 2 : W + 2);
    chk_results("done", v);
    @(negedge clk);
    chk("done_one_cycle", bus.done_parallel_division, 0);
    chk("idle_after_done", bus.busy, 0);
    chk_results("hold", v);
    bus.pagerank  = '0;
    bus.link_mask = '0;
  endtask

  initial begin
    int  t, d0, d1, busy_low;
    bit  seen;
    vec_t v;

    vt[0] = '{32'd1000,       10'h007, 32'd333,       32'd1, 1'b0};
    vt[1] = '{32'hFFFF_FFFF,  10'h3FF, 32'd429496729, 32'd5, 1'b0};
    vt[2] = '{32'd500,        10'h000, 32'd0,         32'd0, 1'b1};
    vt[3] = '{32'd0,          10'h155, 32'd0,         32'd0, 1'b0};
    vt[4] = '{32'd7,          10'h001, 32'd7,         32'd0, 1'b0};
    vt[5] = '{32'd100,        10'h201, 32'd50,        32'd0, 1'b0};
    vt[6] = '{32'd1234567,    10'h0F0, 32'd308641,    32'd3, 1'b0};
    vt[7] = '{32'd999,        10'h3F8, 32'd142,       32'd5, 1'b0};
    vt[8] = '{32'd12345,      10'h2AA, 32'd2469,      32'd0, 1'b0};

    reset         = 1'b1;
    bus.start     = 1'b1;
    bus.pagerank  = 32'd55;
    bus.link_mask = 10'h003;
    repeat (3) @(negedge clk);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done_parallel_division, 0);
    chk("rst enable", bus.enable, 0);
    chk("rst remainder", bus.remainder, 0);
    chk("rst dangling", bus.dangling, 0);
    chk("rst lanes", |bus.partial_pagerank, 0);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++)
      run_req(vt[i], i == 6);

    // Continuous start: pulses WIDTH+3 apart, one IDLE cycle between.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.pagerank  = 32'd1000;
    bus.link_mask = 10'h007;
    d0 = -1;
    d1 = -1;
    busy_low = 0;
    t = 0;
    while (d1 < 0 && t < 200) begin
      @(negedge clk);
      t++;
      if (d0 >= 0 && !bus.busy) busy_low++;
      if (bus.done_parallel_division) begin
        if (d0 < 0) d0 = t;
        else        d1 = t;
      end
    end
    bus.start = 1'b0;
    chk("stream spacing", d1 - d0, W + 3);
    chk("stream idle gap", busy_low, 1);
    v = vt[0];
    chk_results("stream", v);
    repeat (3) @(negedge clk);

    // Reset in the middle of DIVIDE aborts without a done pulse.
    bus.start     = 1'b1;
    bus.pagerank  = 32'd1000;
    bus.link_mask = 10'h007;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (11) @(negedge clk);
    chk("abort still busy", bus.busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort busy", bus.busy, 0);
    chk("abort enable", bus.enable, 0);
    chk("abort remainder", bus.remainder, 0);
    chk("abort lanes", |bus.partial_pagerank, 0);
    chk("abort done", bus.done_parallel_division, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_parallel_division) seen = 1'b1;
    end
    chk("abort no done", seen, 0);
    run_req(vt[4], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
